dff_bank_arbiter: RTL
=====================

Name: dff_bank_arbiter

Overview:
- Shares one WIDTH-bit register bank (a row of gate-level D flip-flops with common clock and clear) between two requesters.
- Arbitrates round-robin and drives the bank's data and load-enable.
- Holds the bank busy for a programmable number of settle cycles to cover gate propagation delay.
- Reads the bank back, pulses completion to the winner and flags any mismatch.

Parameters:
- WIDTH, 4, data width of the shared bank and of each requester's write data.
- SETTLE_CYCLES, 2, cycles the bank is held after a load before readback; legal range 1..15.

Ports:
- clock  input  1  single system clock; all state updates on its rising edge.
- clear  input  1  asynchronous active-low reset.
- req0  input  1  requester 0 write request; level, held until done0 or abandoned.
- data0  input  WIDTH  requester 0 write data.
- req1  input  1  requester 1 write request.
- data1  input  WIDTH  requester 1 write data.
- gnt0  output  1  requester 0 owns the bank.
- gnt1  output  1  requester 1 owns the bank.
- done0  output  1  one-cycle completion pulse to requester 0.
- done1  output  1  one-cycle completion pulse to requester 1.
- bank_d  output  WIDTH  data presented to the bank D inputs.
- bank_we  output  1  one-cycle load enable to the bank.
- bank_q  input  WIDTH  bank Q outputs, fed back for readback.
- busy  output  1  high in every state except IDLE.
- verify_err  output  1  one-cycle pulse when readback differs from the written data.

Behaviour:
- Reset (clear low, asynchronous):
  - State goes to IDLE and the round-robin pointer favours req0.
  - Captured data and settle counter are cleared.
  - gnt0, gnt1, done0, done1, bank_we, busy and verify_err are 0; bank_d is 0.
  - Reset asserted mid-transaction aborts it immediately with no done pulse. A bank_we in flight is dropped.
- All outputs are registered or decoded from registered state; there is no combinational path from req to gnt.
- States are IDLE, GRANT, WRITE, SETTLE and CHECK.
- IDLE:
  - No request: stay in IDLE.
  - One request: that requester wins.
  - Both requests: the requester indicated by the pointer wins.
  - On the edge that leaves IDLE, register the winner ID, capture the winner's data into the hold register, and go to GRANT.
- GRANT (1 cycle):
  - gnt of the winner is high; bank_d equals the hold register.
  - If the winner's req is low at the edge, abandon and return to IDLE. No write occurs, no done pulse, pointer unchanged.
  - Otherwise go to WRITE.
- WRITE (1 cycle): bank_we=1, then go to SETTLE with counter loaded to SETTLE_CYCLES.
- SETTLE: lasts exactly SETTLE_CYCLES cycles, decrementing each cycle; go to CHECK when the count expires. A req drop here is ignored; the transaction completes.
- CHECK (1 cycle):
  - done of the winner is high.
  - verify_err = (bank_q != hold register).
  - The pointer flips to the other requester.
  - Next state is IDLE.
- gnt of the winner stays high from GRANT through CHECK inclusive. bank_d holds the captured value for that whole span and is 0 in IDLE.
- Latency (req sampled at edge k): gnt in cycle k+1, bank_we in cycle k+2, done in cycle k+3+SETTLE_CYCLES, IDLE again in cycle k+4+SETTLE_CYCLES.
- Back-to-back traffic has a minimum of one IDLE cycle between transactions.
- Changes to data0/data1 after capture have no effect on the current transaction.
- gnt0 and gnt1 are never high together; done0 and done1 are never high together.

Decomposition:
- Shared package dff_bank_pkg holds:
  - state encoding localparams ST_IDLE, ST_GRANT, ST_WRITE, ST_SETTLE, ST_CHECK (3-bit);
  - requester ID constants REQ0=0, REQ1=1;
  - SETTLE_MAX=15.
- One sub-module, settle_timer: 4-bit load/decrement counter with an expire flag. Same clock and clear.
- Arbitration and FSM stay in the top module.

Test Plan:
- Reset: drive clear=0 with req0=1 and req1=1 for 3 cycles -> all outputs 0 and busy=0. Release clear -> gnt0 in the next cycle, gnt1 stays 0.
- Single write, WIDTH=4, SETTLE_CYCLES=2: req0 with data0=4'hA sampled at edge 0, bank model returns data after one cycle -> gnt0 high cycles 1-5, bank_we only in cycle 2, bank_d=4'hA, done0 in cycle 5, verify_err=0, busy low in cycle 6.
- Contention: req0 and req1 held continuously with data0=4'h3, data1=4'hC -> grants alternate gnt0, gnt1, gnt0; bank_q sequence 3, C, 3; exactly one IDLE cycle between grants.
- Abandon: req1 alone, dropped during GRANT -> no bank_we, no done1, back to IDLE. A following simultaneous req0 and req1 still grants req1 (pointer unchanged).
- Verify error: bank model forces bank_q=4'h0 after a write of 4'h5 -> verify_err pulses once in the done cycle, with done0 also high.
- Mid-transaction reset: assert clear during SETTLE -> outputs 0 at once, no done pulse. After release, a pending req1 is granted before req0 (pointer reset favours req0 only when both request; here only req1 requests).

Source files
------------

// File: rtl/dff_bank_pkg.sv
// rtl/dff_bank_pkg.sv - shared types and constants for the DFF bank arbiter
// Contents: FSM state encoding, requester IDs, settle-count ceiling.
package dff_bank_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_GRANT  = 3'd1,
      ST_WRITE  = 3'd2,
      ST_SETTLE = 3'd3,
      ST_CHECK  = 3'd4
   } state_t;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

   // Largest settle count the 4-bit timer can hold.
   localparam int SETTLE_MAX = 15;

endpackage

// File: rtl/dff_bank_arbiter_settle_timer.sv
// rtl/dff_bank_arbiter_settle_timer.sv - 4-bit load/decrement settle counter
// Ports:
//   clock, clear    : system clock, asynchronous active-low reset
//   load, load_val  : load the counter with load_val (wins over dec)
//   dec             : decrement by one, holding at zero
//   expire          : high during the last counted cycle (count == 1)
module settle_timer (
   input  logic       clock,
   input  logic       clear,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   output logic       expire
);

   logic [3:0] count;

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         count <= 4'd0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != 4'd0)) begin
         count <= count - 4'd1;
      end
   end

   // Flagging at one rather than zero lets a load of N yield exactly N
   // counted cycles before the owner moves on.
   assign expire = (count == 4'd1);

endmodule

// File: rtl/dff_bank_arbiter.sv
// rtl/dff_bank_arbiter.sv - round-robin arbiter sharing one DFF register bank
// Ports:
//   clock, clear        : system clock, asynchronous active-low reset
//   req0/data0          : requester 0 write request (level) and data
//   req1/data1          : requester 1 write request (level) and data
//   gnt0/gnt1           : bank ownership, GRANT through CHECK
//   done0/done1         : one-cycle completion pulse in CHECK
//   bank_d/bank_we      : bank D inputs and one-cycle load enable
//   bank_q              : bank Q outputs for readback
//   busy                : high whenever not IDLE
//   verify_err          : one-cycle pulse in CHECK when readback mismatches
module dff_bank_arbiter
   import dff_bank_pkg::*;
#(
   parameter int WIDTH         = 4,
   parameter int SETTLE_CYCLES = 2   // legal range 1..SETTLE_MAX
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             req0,
   input  logic [WIDTH-1:0] data0,
   input  logic             req1,
   input  logic [WIDTH-1:0] data1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             done0,
   output logic             done1,
   output logic [WIDTH-1:0] bank_d,
   output logic             bank_we,
   input  logic [WIDTH-1:0] bank_q,
   output logic             busy,
   output logic             verify_err
);

   localparam logic [3:0] SETTLE_LOAD = SETTLE_CYCLES[3:0];

   state_t           state_q, state_d;
   logic             winner_q;
   logic             ptr_q;
   logic [WIDTH-1:0] hold_q;
   logic             take;
   logic             pick;
   logic             winner_req;
   logic             expire;

   // Pointer only breaks ties; a lone requester always wins.
   assign pick       = (req0 && req1) ? ptr_q : (req1 ? REQ1 : REQ0);
   assign winner_req = (winner_q == REQ1) ? req1 : req0;

   always_comb begin
      state_d = state_q;
      take    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req0 || req1) begin
               take    = 1'b1;
               state_d = ST_GRANT;
            end
         end
         ST_GRANT:  state_d = winner_req ? ST_WRITE : ST_IDLE;
         ST_WRITE:  state_d = ST_SETTLE;
         ST_SETTLE: if (expire) state_d = ST_CHECK;
         ST_CHECK:  state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q  <= ST_IDLE;
         winner_q <= REQ0;
         ptr_q    <= REQ0;
         hold_q   <= '0;
      end else begin
         state_q <= state_d;
         if (take) begin
            winner_q <= pick;
            hold_q   <= (pick == REQ1) ? data1 : data0;
         end
         // Only a completed transaction advances the pointer; an abandon
         // in GRANT leaves it where it was.
         if (state_q == ST_CHECK) begin
            ptr_q <= ~winner_q;
         end
      end
   end

   settle_timer u_settle_timer (
      .clock    (clock),
      .clear    (clear),
      .load     (state_q == ST_WRITE),
      .load_val (SETTLE_LOAD),
      .dec      (state_q == ST_SETTLE),
      .expire   (expire)
   );

   assign busy       = (state_q != ST_IDLE);
   assign gnt0       = busy && (winner_q == REQ0);
   assign gnt1       = busy && (winner_q == REQ1);
   assign bank_d     = busy ? hold_q : '0;
   assign bank_we    = (state_q == ST_WRITE);
   assign done0      = (state_q == ST_CHECK) && (winner_q == REQ0);
   assign done1      = (state_q == ST_CHECK) && (winner_q == REQ1);
   assign verify_err = (state_q == ST_CHECK) && (bank_q != hold_q);

endmodule
